// File: rtl/req_merge_arbiter_pkg.sv
// Shared widths, source encodings and helpers for the two-channel request merge arbiter.
// The codebase-wide width and source-tag macros are defined here, ahead of the package.
`ifndef REQ_MERGE_DEFINES
`define REQ_MERGE_DEFINES
`define ADDRESS_WIDTH 32
`define ID_WIDTH 8
`define SRC_CH1 1'b0
`define SRC_CH2 1'b1
`endif

package req_merge_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF     = `ADDRESS_WIDTH;
    localparam int unsigned ID_W_DEF       = `ID_WIDTH;
    localparam int unsigned FIFO_DEPTH_DEF = 4;
    localparam int unsigned DROP_W         = 8;
    localparam int unsigned DROP_SUM_W     = DROP_W + 1;

    localparam logic SRC_CH1 = `SRC_CH1;
    localparam logic SRC_CH2 = `SRC_CH2;

    // Add up to three drops per cycle, sticking at all-ones.
    function automatic logic [DROP_W-1:0] drop_sat_add(input logic [DROP_W-1:0] cnt,
                                                       input logic [1:0]        inc);
        logic [DROP_SUM_W-1:0] sum;
        sum = DROP_SUM_W'(cnt) + DROP_SUM_W'(inc);
        return sum[DROP_W] ? '1 : sum[DROP_W-1:0];
    endfunction

endpackage

// File: rtl/req_kill_fifo.sv
// Small request FIFO whose entries carry a kill bit; a flush marks every stored
// entry (and a same-cycle push) whose id matches.
module req_kill_fifo
    import req_merge_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned ID_W   = ID_W_DEF,
    parameter int unsigned DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_address,
    input  logic [ID_W-1:0]   push_id,
    input  logic              pop,
    input  logic              flush,
    input  logic [ID_W-1:0]   flush_id,
    output logic              full,
    output logic [ADDR_W-1:0] head_address,
    output logic [ID_W-1:0]   head_id,
    output logic              head_live,
    output logic              head_killed
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [ID_W-1:0]   id_q   [DEPTH];
    logic [ID_W-1:0]   id_d   [DEPTH];
    logic [DEPTH-1:0]  kill_q, kill_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              empty, push_ok, pop_ok;

    assign empty        = (count_q == '0);
    assign full         = (count_q == CNT_W'(DEPTH));
    assign push_ok      = push && !full;
    assign pop_ok       = pop && !empty;
    assign head_address = addr_q[rd_ptr_q];
    assign head_id      = id_q[rd_ptr_q];
    assign head_live    = !empty && !kill_q[rd_ptr_q];
    assign head_killed  = !empty && kill_q[rd_ptr_q];

    always_comb begin
        addr_d   = addr_q;
        id_d     = id_q;
        kill_d   = kill_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Parallel id compare across all slots.
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (flush && (id_q[PTR_W'(i)] == flush_id)) begin
                kill_d[PTR_W'(i)] = 1'b1;
            end
        end
        if (push_ok) begin
            addr_d[wr_ptr_q] = push_address;
            id_d[wr_ptr_q]   = push_id;
            kill_d[wr_ptr_q] = flush && (push_id == flush_id);
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[PTR_W'(i)] <= '0;
                id_q[PTR_W'(i)]   <= '0;
            end
            kill_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            addr_q   <= addr_d;
            id_q     <= id_d;
            kill_q   <= kill_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/req_merge_arbiter.sv
// Merges two producer request channels onto one registered downstream port with
// round-robin arbitration, id-based flush kills and serialised flush forwarding.
module req_merge_arbiter
    import req_merge_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned ID_W       = ID_W_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] in_address_1,
    input  logic [ID_W-1:0]   in_id_1,
    input  logic              in_valid_1,
    output logic              out_stall_1,
    input  logic              flush_1,
    input  logic [ID_W-1:0]   flush_id_1,
    input  logic [ADDR_W-1:0] in_address_2,
    input  logic [ID_W-1:0]   in_id_2,
    input  logic              in_valid_2,
    output logic              out_stall_2,
    input  logic              flush_2,
    input  logic [ID_W-1:0]   flush_id_2,
    output logic [ADDR_W-1:0] out_address,
    output logic [ID_W-1:0]   out_id,
    output logic              out_valid,
    output logic              out_src,
    input  logic              in_stall,
    output logic              flush_out,
    output logic [ID_W-1:0]   flush_id_out,
    output logic [7:0]        drop_count
);

    logic [ADDR_W-1:0] head_address_1, head_address_2;
    logic [ID_W-1:0]   head_id_1, head_id_2;
    logic              head_live_1, head_live_2, head_killed_1, head_killed_2;
    logic              pop_1, pop_2;

    logic              grant_valid, grant_src, grant_flushed, take, stage_flush;
    logic [ADDR_W-1:0] grant_address;
    logic [ID_W-1:0]   grant_id;
    logic [1:0]        drop_inc;

    logic [ADDR_W-1:0] out_address_q, out_address_d;
    logic [ID_W-1:0]   out_id_q, out_id_d;
    logic              out_valid_q, out_valid_d, out_src_q, out_src_d;
    logic              last_grant_q, last_grant_d;
    logic              flush_out_q, flush_out_d;
    logic [ID_W-1:0]   flush_id_out_q, flush_id_out_d;
    logic              pend_valid_q, pend_valid_d;
    logic [ID_W-1:0]   pend_id_q, pend_id_d;
    logic [DROP_W-1:0] drop_count_q, drop_count_d;

    req_kill_fifo #(.ADDR_W(ADDR_W), .ID_W(ID_W), .DEPTH(FIFO_DEPTH)) u_fifo_1 (
        .clk(clk), .reset(reset),
        .push(in_valid_1), .push_address(in_address_1), .push_id(in_id_1),
        .pop(pop_1), .flush(flush_1), .flush_id(flush_id_1),
        .full(out_stall_1), .head_address(head_address_1), .head_id(head_id_1),
        .head_live(head_live_1), .head_killed(head_killed_1)
    );

    req_kill_fifo #(.ADDR_W(ADDR_W), .ID_W(ID_W), .DEPTH(FIFO_DEPTH)) u_fifo_2 (
        .clk(clk), .reset(reset),
        .push(in_valid_2), .push_address(in_address_2), .push_id(in_id_2),
        .pop(pop_2), .flush(flush_2), .flush_id(flush_id_2),
        .full(out_stall_2), .head_address(head_address_2), .head_id(head_id_2),
        .head_live(head_live_2), .head_killed(head_killed_2)
    );

    // Round-robin pick among live heads; a head matching this cycle's flush is still popped.
    always_comb begin
        grant_valid = head_live_1 || head_live_2;
        if (head_live_1 && head_live_2) begin
            grant_src = ~last_grant_q;
        end else begin
            grant_src = head_live_2 ? SRC_CH2 : SRC_CH1;
        end
        grant_address = (grant_src == SRC_CH2) ? head_address_2 : head_address_1;
        grant_id      = (grant_src == SRC_CH2) ? head_id_2 : head_id_1;
        grant_flushed = (grant_src == SRC_CH2) ? (flush_2 && (head_id_2 == flush_id_2))
                                               : (flush_1 && (head_id_1 == flush_id_1));
        stage_flush   = (out_src_q == SRC_CH2) ? (flush_2 && (out_id_q == flush_id_2))
                                               : (flush_1 && (out_id_q == flush_id_1));
        take  = grant_valid && !in_stall;
        pop_1 = head_killed_1 || (take && (grant_src == SRC_CH1));
        pop_2 = head_killed_2 || (take && (grant_src == SRC_CH2));
    end

    // Output stage, drop counter and flush forwarding.
    always_comb begin
        out_address_d  = out_address_q;
        out_id_d       = out_id_q;
        out_valid_d    = out_valid_q;
        out_src_d      = out_src_q;
        last_grant_d   = last_grant_q;
        flush_out_d    = 1'b0;
        flush_id_out_d = flush_id_out_q;
        pend_valid_d   = pend_valid_q;
        pend_id_d      = pend_id_q;
        drop_inc       = 2'(head_killed_1) + 2'(head_killed_2);

        if (!in_stall) begin
            if (take) begin
                last_grant_d = grant_src;
                if (grant_flushed) begin
                    out_valid_d = 1'b0;
                    drop_inc    = drop_inc + 2'(1);
                end else begin
                    out_address_d = grant_address;
                    out_id_d      = grant_id;
                    out_valid_d   = 1'b1;
                    out_src_d     = grant_src;
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (out_valid_q && stage_flush) begin
            out_valid_d = 1'b0;
            drop_inc    = drop_inc + 2'(1);
        end
        drop_count_d = drop_sat_add(drop_count_q, drop_inc);

        // A pending channel-2 flush goes first; anything arriving alongside it is lost.
        if (pend_valid_q) begin
            flush_out_d    = 1'b1;
            flush_id_out_d = pend_id_q;
            pend_valid_d   = 1'b0;
        end else if (flush_1) begin
            flush_out_d    = 1'b1;
            flush_id_out_d = flush_id_1;
            if (flush_2) begin
                pend_valid_d = 1'b1;
                pend_id_d    = flush_id_2;
            end
        end else if (flush_2) begin
            flush_out_d    = 1'b1;
            flush_id_out_d = flush_id_2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_address_q  <= '0;
            out_id_q       <= '0;
            out_valid_q    <= 1'b0;
            out_src_q      <= 1'b0;
            last_grant_q   <= SRC_CH2;
            flush_out_q    <= 1'b0;
            flush_id_out_q <= '0;
            pend_valid_q   <= 1'b0;
            pend_id_q      <= '0;
            drop_count_q   <= '0;
        end else begin
            out_address_q  <= out_address_d;
            out_id_q       <= out_id_d;
            out_valid_q    <= out_valid_d;
            out_src_q      <= out_src_d;
            last_grant_q   <= last_grant_d;
            flush_out_q    <= flush_out_d;
            flush_id_out_q <= flush_id_out_d;
            pend_valid_q   <= pend_valid_d;
            pend_id_q      <= pend_id_d;
            drop_count_q   <= drop_count_d;
        end
    end

    assign out_address  = out_address_q;
    assign out_id       = out_id_q;
    assign out_valid    = out_valid_q;
    assign out_src      = out_src_q;
    assign flush_out    = flush_out_q;
    assign flush_id_out = flush_id_out_q;
    assign drop_count   = drop_count_q;

endmodule

// File: doc/req_merge_arbiter.md
Name: req_merge_arbiter

Overview:
- Merges the two producer request channels (address/id/valid with stall back-pressure) onto one downstream request port.
- Each channel feeds its own small FIFO. A round-robin arbiter drains the FIFOs into a registered output stage.
- Per-channel flush requests kill every queued or staged request with a matching id and are forwarded downstream, one per cycle.
- Sits between the producer and the consumer/cache pipeline.

Parameters:
- ADDR_W, `ADDRESS_WIDTH, request address width
- ID_W, `ID_WIDTH (8), request id width; upper nibble = source tag, lower nibble = sequence
- FIFO_DEPTH, 4, entries per input FIFO (power of two, ≥2)

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- in_address_1  in  ADDR_W  channel 1 request address
- in_id_1  in  ID_W  channel 1 request id
- in_valid_1  in  1  channel 1 request valid
- out_stall_1  out  1  back-pressure to channel 1
- flush_1  in  1  channel 1 flush pulse
- flush_id_1  in  ID_W  id to kill on channel 1
- in_address_2, in_id_2, in_valid_2, out_stall_2, flush_2, flush_id_2: same as channel 1, for channel 2
- out_address  out  ADDR_W  merged request address
- out_id  out  ID_W  merged request id
- out_valid  out  1  merged request valid
- out_src  out  1  0 = channel 1, 1 = channel 2
- in_stall  in  1  downstream back-pressure
- flush_out  out  1  forwarded flush pulse
- flush_id_out  out  ID_W  forwarded flush id
- drop_count  out  8  saturating count of killed requests

Behaviour:
- Reset: all FIFOs empty, kill bits cleared, all outputs 0, last_grant = 1 (so channel 1 wins first), pending flush cleared.
- Push rule:
  - out_stall_N = (count_N == FIFO_DEPTH), driven combinationally from the count register.
  - A request is accepted when in_valid_N && !out_stall_N; it is stored as {address, id, kill=0}.
- Live head: a FIFO is "live" when it is non-empty and its head kill bit = 0.
- Killed heads:
  - A head with kill = 1 is popped and discarded every cycle, independent of in_stall. It is never granted.
  - Each discard increments drop_count, saturating at 255.
- Output stage update, only when !in_stall:
  - If either FIFO head is live, grant round-robin: if both are live, the channel ≠ last_grant wins; otherwise the only live one wins.
  - Pop the winner into out_*, set out_valid = 1, out_src = winner, last_grant = winner.
  - If no head is live, out_valid <= 0.
- When in_stall = 1: the output stage holds, no grant is made, and last_grant is unchanged.
- Latency: a request pushed into an empty FIFO appears on out_* two clock edges later (push edge, then grant edge), with in_stall low.
- Flush on channel N (pulse, one cycle), all taking effect at the same edge:
  - Every FIFO_N entry with id == flush_id_N gets kill = 1.
  - An incoming channel-N request with a matching id, pushed that cycle, is stored with kill = 1.
  - A head popped that same edge with a matching id is treated as killed: not loaded, counted in drop_count.
  - If the output stage holds out_src == N, out_id == flush_id_N, and in_stall = 1, then out_valid <= 0 and drop_count increments.
  - Entries of the other channel are never affected.
- Flush forwarding:
  - flush_out/flush_id_out are registered, one cycle after flush_N.
  - If flush_1 and flush_2 arrive together, channel 1 is forwarded first and channel 2 is held in a one-entry pending register, then forwarded the next cycle.
  - A pending flush has priority over new flushes. A new flush arriving while the pending register is occupied is a protocol error: the new flush is dropped, and the bench asserts this never happens.
- Simultaneous push and pop on the same FIFO: allowed; count is unchanged.
- Pointers wrap modulo FIFO_DEPTH. Count is $clog2(FIFO_DEPTH)+1 bits wide.
- Reset asserted mid-operation: all state clears immediately, queued requests are lost, and no flush is forwarded.

Decomposition:
- defines.vh supplies ADDRESS_WIDTH and ID_WIDTH; add SRC_CH1 = 0 and SRC_CH2 = 1 there.
- One sub-module, req_kill_fifo, instantiated twice. It contains:
  - the storage;
  - per-entry kill bits with a parallel id compare;
  - the push/pop logic;
  - head_live/head_killed flags.
- The arbiter, output stage, flush forwarding and drop counter live in the top level.

Test Plan:
- Channel 1 only, ids 0x11..0x14, in_stall = 0:
  - out_id 0x11, 0x12, 0x13, 0x14 on consecutive cycles, first one two edges after push.
  - out_src = 0 throughout; out_stall_1 never asserted.
- Both channels are continuous, ids 0x11.. and 0x21..:
  - Output strictly alternates 0x11, 0x21, 0x12, 0x22, ...
- Hold in_stall = 1 for 6 cycles while channel 1 streams:
  - out_stall_1 rises after 4 accepts.
  - out_* is held steady.
  - On release, 0x11..0x15 drain in order with no loss or duplicate.
- Queue 0x11–0x14 on channel 1 with in_stall high, then pulse flush_1 with id 0x16, then with id 0x13:
  - The 0x16 flush drops nothing.
  - The 0x13 flush: after release, output is 0x11, 0x12, 0x14; drop_count = 1; flush_out with id 0x13 appears one cycle after the pulse.
- Flush channel 2 with id 0x13 while 0x13 is queued on channel 1:
  - Nothing is dropped; drop_count stays 0.
- flush_1 (id 0x15) and flush_2 (id 0x25) in the same cycle:
  - flush_out/flush_id_out shows 0x15, then 0x25 on the next cycle.
  - Then assert reset mid-stream: all outputs go to 0 immediately and FIFOs are empty afterwards.
